spmv_host_doorbell: RTL and testbench
=====================================

# spmv_host_doorbell

Host-side initiator for the SpMV engine's SRAM mailbox. It loads operand words into SRAM A, rings the doorbell by writing 1 to word 0 of A, and polls word 0 until the engine clears it on completion. It then streams the result words out of SRAM B. It drives the second port of the dual-port SRAMs; the SpMV ops controller owns the first port.

## Interface
Parameters:
- DATA_W, 256, SRAM word width
- ADDR_W, 5, SRAM address width (32 words)
- TIMEOUT, 4096, maximum poll cycles in WAIT; 0 disables the timeout

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle command pulse; ignored unless state is IDLE
- i_load_words  in  5  number of operand words, 0..31, written to A[1..n]; sampled with i_start
- i_result_words  in  6  number of result words, 0..32, read from B[0..m-1]; sampled with i_start
- i_in_valid / o_in_ready / i_in_data  in/out/in  1/1/DATA_W  operand stream
- o_out_valid / i_out_ready / o_out_data  out/in/out  1/1/DATA_W  result stream
- o_address_A, o_wr_en_A, o_write_data_A  out  ADDR_W/1/DATA_W  SRAM A port 1
- i_read_data_A  in  DATA_W  SRAM A port 1 read data
- o_address_B  out  ADDR_W  SRAM B port 1, read-only
- i_read_data_B  in  DATA_W  SRAM B port 1 read data
- o_busy  out  1  high in every state other than IDLE
- o_done  out  1  one-cycle pulse after the last result word is accepted
- o_error  out  1  one-cycle pulse on poll timeout
- o_state  out  3  current FSM state, for debug

## Operation
- States (3-bit encoding): IDLE=0, LOAD=1, RING=2, WAIT=3, UNLOAD=4, FIN=5.
- IDLE:
  - On i_start, latch both counts.
  - Go to LOAD if load_words≠0, otherwise go to RING.
- LOAD:
  - o_in_ready=1.
  - Each beat (valid&ready) writes i_in_data to A[wr_ptr], with wr_ptr starting at 1, in the same cycle.
  - After beat number load_words, go to RING.
- RING:
  - Write A[0] = {224'b0, 32'h1} for one cycle, then go to WAIT.
  - Clear the poll counter.
- WAIT:
  - Drive o_address_A=0 with o_wr_en_A=0 every cycle.
  - SRAM read latency is 1 cycle, so the first sample is taken on the 2nd WAIT cycle.
  - When a sample has i_read_data_A[31:0]==0, the engine has cleared the flag: go to UNLOAD if result_words≠0, otherwise go to FIN.
  - The poll counter increments every WAIT cycle. When TIMEOUT≠0 and the counter reaches TIMEOUT: pulse o_error, go to IDLE, and leave the flag untouched (no write).
- UNLOAD:
  - Issue B reads at addresses 0..m-1, one per cycle, while the skid buffer has space for the in-flight read.
  - Returned data enters a 2-entry skid buffer, which drives the out stream.
  - Go to FIN once m words have been accepted downstream.
- FIN: pulse o_done for one cycle, then go to IDLE.
- Outside LOAD/RING, o_wr_en_A=0. o_write_data_A is a don't-care when o_wr_en_A=0 (drive 0).
- In IDLE, addresses are 0 and no writes occur.

## Timing
- Reset values:
  - state = IDLE.
  - All addresses, write enables and write data = 0.
  - o_in_ready=0, o_out_valid=0, o_busy=0, o_done=0, o_error=0.
  - Counters and skid buffer cleared.
- i_start in cycle t: o_busy=1 and o_in_ready=1 from cycle t+1.
- Last LOAD beat in cycle t: RING write in t+1; WAIT from t+2.
- The earliest flag-clear detection uses read data from the 2nd WAIT cycle onward. A stale value of 1 from the RING cycle must never be sampled as 0.
- UNLOAD:
  - The first read address is presented in the first UNLOAD cycle.
  - o_out_valid rises 1 cycle later.
  - Sustained throughput is 1 word/cycle with i_out_ready held high.
  - Under backpressure there is no loss and no duplication. Reads stall when 2 words are buffered or in flight.
- o_out_data is stable while o_out_valid && !i_out_ready.
- i_in_valid outside LOAD is ignored. A beat is counted only when valid&ready.
- i_start while busy: no effect.
- i_start with both counts 0: RING, WAIT, FIN; o_done follows flag clear.
- Asynchronous reset at any point: immediate return to IDLE. Skid contents are discarded. Writes already completed to A remain in the SRAM.
- Address arithmetic is unsigned ADDR_W with no wrap: the maximum wr_ptr is 31 and the maximum B address is 31.

## Structure
- Package spmv_pkg holds:
  - DATA_W and ADDR_W.
  - The state encoding constants.
  - FLAG_ADDR=0, FLAG_SET=32'h1, FLAG_CLR=32'h0.
- Sub-module spmv_rd_skid: a 2-entry valid/ready buffer with an occupancy-based read-issue credit output, used by UNLOAD.

## Test plan
- Load 3 words (0xA1, 0xA2, 0xA3) → A[1..3] written on consecutive beats, then A[0]=1 in the following cycle.
- Model clears A[0] 10 cycles after the ring; result_words=4, B[0..3]=0xB0..0xB3 → out stream emits 0xB0..0xB3 in order, followed by a single o_done pulse.
- Toggle i_out_ready at a 50% random pattern during a 32-word unload → all 32 words emitted, no duplicates, data stable while stalled.
- Model never clears the flag with TIMEOUT=16 → o_error pulse after 16 WAIT cycles, o_busy=0, A[0] stays 1.
- Counts 0/0 → no LOAD beats, ring, o_done 1 cycle after the clear is sampled; i_start pulsed mid-WAIT is ignored.
- Assert i_rstn low mid-UNLOAD → all outputs at reset values immediately; a fresh i_start afterwards runs normally.

Source files
------------

// File: rtl/spmv_pkg.sv
// Shared widths, FSM encoding and mailbox flag constants for the SpMV host doorbell.
package spmv_pkg;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RING   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UNLOAD = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    localparam int          FLAG_ADDR = 0;
    localparam logic [31:0] FLAG_SET  = 32'h1;
    localparam logic [31:0] FLAG_CLR  = 32'h0;

endpackage

// File: rtl/spmv_rd_skid.sv
// Two-entry valid/ready buffer behind a 1-cycle-latency SRAM read port.
// o_credit says whether one more read may be issued without overflowing the buffer.
module spmv_rd_skid #(
    parameter int DATA_W = spmv_pkg::DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_issue,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_credit,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);
    import spmv_pkg::*;

    logic              inflight;
    logic [1:0]        count;
    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;
    logic              pop;
    logic [2:0]        occ_after_pop;

    // Returning data bypasses the empty buffer so valid rises one cycle after the read.
    assign o_valid       = (count != 2'd0) || inflight;
    assign o_data        = (count != 2'd0) ? ent0 : i_rd_data;
    assign pop           = o_valid && i_ready;
    assign occ_after_pop = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign o_credit      = occ_after_pop < 3'd2;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            inflight <= 1'b0;
            count    <= 2'd0;
            ent0     <= '0;
            ent1     <= '0;
        end else begin
            inflight <= i_issue;
            case ({inflight, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= i_rd_data;
                    else               ent1 <= i_rd_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= i_rd_data;
                    end else if (count == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= i_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/spmv_host_doorbell.sv
// Host-side mailbox initiator: loads operands into SRAM A, rings and polls the
// doorbell word A[0], then streams results out of SRAM B.
//
// state  | meaning
// IDLE   | waiting for i_start, SRAM ports quiet
// LOAD   | accepting operand beats into A[1..n]
// RING   | writing the doorbell flag A[0]=1
// WAIT   | polling A[0] until the engine clears it or the poll times out
// UNLOAD | reading B[0..m-1] through the skid buffer to the out stream
// FIN    | one-cycle completion pulse
module spmv_host_doorbell #(
    parameter int          DATA_W  = spmv_pkg::DATA_W,
    parameter int          ADDR_W  = spmv_pkg::ADDR_W,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [4:0]        i_load_words,
    input  logic [5:0]        i_result_words,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [ADDR_W-1:0] o_address_A,
    output logic              o_wr_en_A,
    output logic [DATA_W-1:0] o_write_data_A,
    input  logic [DATA_W-1:0] i_read_data_A,
    output logic [ADDR_W-1:0] o_address_B,
    input  logic [DATA_W-1:0] i_read_data_B,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [2:0]        o_state
);
    import spmv_pkg::*;

    state_t      state;
    logic [4:0]  load_words;
    logic [5:0]  result_words;
    logic [4:0]  wr_ptr;
    logic [31:0] poll_cnt;
    logic [5:0]  rd_cnt;
    logic [5:0]  acc_cnt;
    logic        rd_credit;
    logic        rd_issue;
    logic        in_fire;
    logic        out_fire;
    logic        flag_clear;
    logic        poll_expired;
    logic        unused_rd_a;

    assign unused_rd_a = ^i_read_data_A[DATA_W-1:32];

    assign in_fire      = o_in_ready && i_in_valid;
    assign out_fire     = o_out_valid && i_out_ready;
    assign rd_issue     = (state == ST_UNLOAD) && (rd_cnt < result_words) && rd_credit;
    // The first WAIT cycle still returns the read launched alongside the RING write.
    assign flag_clear   = (poll_cnt != 32'd0) && (i_read_data_A[31:0] == FLAG_CLR);
    assign poll_expired = (TIMEOUT != 0) && (poll_cnt + 32'd1 == TIMEOUT);
    assign o_state      = state;
    assign o_address_B  = (state == ST_UNLOAD) ? ADDR_W'(rd_cnt) : '0;

    always_comb begin
        o_address_A    = '0;
        o_wr_en_A      = 1'b0;
        o_write_data_A = '0;
        if (state == ST_LOAD) begin
            o_address_A = ADDR_W'(wr_ptr);
            if (in_fire) begin
                o_wr_en_A      = 1'b1;
                o_write_data_A = i_in_data;
            end
        end else if (state == ST_RING) begin
            o_address_A    = ADDR_W'(FLAG_ADDR);
            o_wr_en_A      = 1'b1;
            o_write_data_A = {{(DATA_W-32){1'b0}}, FLAG_SET};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= ST_IDLE;
            load_words   <= 5'd0;
            result_words <= 6'd0;
            wr_ptr       <= 5'd0;
            poll_cnt     <= 32'd0;
            rd_cnt       <= 6'd0;
            acc_cnt      <= 6'd0;
            o_in_ready   <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_done  <= 1'b0;
            o_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        load_words   <= i_load_words;
                        result_words <= i_result_words;
                        wr_ptr       <= 5'd1;
                        o_busy       <= 1'b1;
                        if (i_load_words != 5'd0) begin
                            state      <= ST_LOAD;
                            o_in_ready <= 1'b1;
                        end else begin
                            state <= ST_RING;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_fire) begin
                        if (wr_ptr == load_words) begin
                            state      <= ST_RING;
                            o_in_ready <= 1'b0;
                        end else begin
                            wr_ptr <= wr_ptr + 5'd1;
                        end
                    end
                end
                ST_RING: begin
                    state    <= ST_WAIT;
                    poll_cnt <= 32'd0;
                end
                ST_WAIT: begin
                    if (poll_cnt != '1) poll_cnt <= poll_cnt + 32'd1;
                    if (flag_clear) begin
                        rd_cnt  <= 6'd0;
                        acc_cnt <= 6'd0;
                        if (result_words != 6'd0) begin
                            state <= ST_UNLOAD;
                        end else begin
                            state  <= ST_FIN;
                            o_done <= 1'b1;
                        end
                    end else if (poll_expired) begin
                        state   <= ST_IDLE;
                        o_busy  <= 1'b0;
                        o_error <= 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (rd_issue) rd_cnt <= rd_cnt + 6'd1;
                    if (out_fire) begin
                        acc_cnt <= acc_cnt + 6'd1;
                        if (acc_cnt + 6'd1 == result_words) begin
                            state  <= ST_FIN;
                            o_done <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    o_busy     <= 1'b0;
                    o_in_ready <= 1'b0;
                end
            endcase
        end
    end

    spmv_rd_skid #(.DATA_W(DATA_W)) u_rd_skid (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_issue   (rd_issue),
        .i_rd_data (i_read_data_B),
        .o_credit  (rd_credit),
        .o_valid   (o_out_valid),
        .i_ready   (i_out_ready),
        .o_data    (o_out_data)
    );

endmodule

// File: tb/tb_spmv_host_doorbell.sv
// Bench for spmv_host_doorbell: SRAM A/B and engine models, stream monitors,
// one task per scenario with inline comparisons against expectations derived here.
module tb_spmv_host_doorbell;

    localparam int DW  = 256;
    localparam int AW  = 5;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_start = 1'b0;
    logic [4:0]    i_load_words = '0;
    logic [5:0]    i_result_words = '0;
    logic          i_in_valid = 1'b0;
    logic          o_in_ready;
    logic [DW-1:0] i_in_data = '0;
    logic          o_out_valid;
    logic          i_out_ready = 1'b1;
    logic [DW-1:0] o_out_data;
    logic [AW-1:0] o_address_A;
    logic          o_wr_en_A;
    logic [DW-1:0] o_write_data_A;
    logic [DW-1:0] rd_a;
    logic [AW-1:0] o_address_B;
    logic [DW-1:0] rd_b;
    logic          o_busy, o_done, o_error;
    logic [2:0]    o_state;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spmv_host_doorbell #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(i_start),
        .i_load_words(i_load_words), .i_result_words(i_result_words),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_address_A(o_address_A), .o_wr_en_A(o_wr_en_A), .o_write_data_A(o_write_data_A),
        .i_read_data_A(rd_a), .o_address_B(o_address_B), .i_read_data_B(rd_b),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_state(o_state)
    );

    // SRAMs with 1-cycle read latency, plus an engine that clears A[0] eng_delay cycles after a ring.
    logic [DW-1:0] mem_a [32];
    logic [DW-1:0] mem_b [32];
    bit eng_en = 1'b0;
    int eng_delay = 10;
    int eng_cnt = 0;

    always @(posedge clk) begin
        rd_a <= mem_a[o_address_A];
        rd_b <= mem_b[o_address_B];
        if (o_wr_en_A) mem_a[o_address_A] <= o_write_data_A;
        if (o_wr_en_A && o_address_A == 0 && o_write_data_A[31:0] == 32'h1) begin
            eng_cnt <= eng_en ? eng_delay : 0;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) mem_a[0] <= '0;
        end
    end

    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        i_out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(1));
    end

    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];
    int            beat_cyc_q[$];
    logic [DW-1:0] out_q[$];
    int            out_cyc_q[$];
    int            done_cyc_q[$];
    int            err_cyc_q[$];
    int            busy_rise_q[$];
    int            wait_cnt = 0;
    int            stall_err = 0;
    bit            stall_prev = 1'b0;
    bit            busy_prev = 1'b0;
    logic [DW-1:0] stall_data;

    always @(negedge clk) begin
        if (rstn) begin
            if (o_wr_en_A) begin
                wr_addr_q.push_back(o_address_A);
                wr_data_q.push_back(o_write_data_A);
                wr_cyc_q.push_back(cyc);
            end
            if (i_in_valid && o_in_ready) beat_cyc_q.push_back(cyc);
            if (o_out_valid && i_out_ready) begin
                out_q.push_back(o_out_data);
                out_cyc_q.push_back(cyc);
            end
            if (stall_prev && (!o_out_valid || o_out_data !== stall_data)) stall_err++;
            stall_prev = o_out_valid && !i_out_ready;
            stall_data = o_out_data;
            if (o_done) done_cyc_q.push_back(cyc);
            if (o_error) err_cyc_q.push_back(cyc);
            if (o_state == 3'd3) wait_cnt++;
            if (o_busy && !busy_prev) busy_rise_q.push_back(cyc);
            busy_prev = o_busy;
        end else begin
            stall_prev = 1'b0;
            busy_prev = 1'b0;
        end
    end

    logic [DW-1:0] op_data [32];
    logic [DW-1:0] b_ref [32];

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        beat_cyc_q.delete(); out_q.delete(); out_cyc_q.delete();
        done_cyc_q.delete(); err_cyc_q.delete(); busy_rise_q.delete();
        wait_cnt = 0;
        stall_err = 0;
    endtask

    task automatic fill_b(input int n);
        for (int i = 0; i < 32; i++) begin
            b_ref[i] = rand_word();
            mem_b[i] = b_ref[i];
        end
    endtask

    task automatic start_cmd(input int nl, input int nr, output int t0);
        t0 = cyc;
        i_start = 1'b1;
        i_load_words = nl[4:0];
        i_result_words = nr[5:0];
        tick();
        i_start = 1'b0;
    endtask

    task automatic feed_ops(input int n, input int valid_pct);
        int sent = 0;
        int guard = 0;
        bit fire;
        while (sent < n && guard < 3000) begin
            i_in_valid = ($urandom_range(99) < valid_pct);
            i_in_data = op_data[sent];
            @(negedge clk);
            fire = i_in_valid && o_in_ready;
            tick();
            if (fire) sent++;
            guard++;
        end
        i_in_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cyc_q.size() != 0 || err_cyc_q.size() != 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #2;
        n_cmp++;
        if ({o_busy, o_done, o_error, o_in_ready, o_out_valid, o_wr_en_A} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000", {o_busy, o_done, o_error, o_in_ready, o_out_valid, o_wr_en_A});
        end
        n_cmp++;
        if (o_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", o_state); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({o_address_A, o_address_B} !== '0 || o_write_data_A !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got A=%0d B=%0d wd=%0h want 0", o_address_A, o_address_B, o_write_data_A[31:0]);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_load();
        int t0, r;
        bit ok;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            mem_b[i] = DW'(32'hB0 + i);
            b_ref[i] = DW'(32'hB0 + i);
        end
        op_data[0] = DW'(32'hA1); op_data[1] = DW'(32'hA2); op_data[2] = DW'(32'hA3);
        eng_en = 1'b1; eng_delay = 10; ready_mode = 0;
        start_cmd(3, 4, t0);
        r = t0 + 4;
        feed_ops(3, 100);
        i_in_valid = 1'b1;
        i_in_data = '1;
        wait_end(300, ok);
        i_in_valid = 1'b0;
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL load_timeout: got no end, want done"); end
        n_cmp++;
        if (busy_rise_q.size() != 1 || busy_rise_q[0] != t0 + 1) begin
            n_fail++; $display("FAIL load_busy_rise: got n=%0d want busy at cycle %0d", busy_rise_q.size(), t0 + 1);
        end
        n_cmp++;
        if (wr_addr_q.size() != 4) begin n_fail++; $display("FAIL load_wr_count: got %0d want 4", wr_addr_q.size()); end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            n_cmp++;
            if (wr_addr_q[i] !== AW'(i + 1) || wr_data_q[i] !== op_data[i] || wr_cyc_q[i] != t0 + 1 + i) begin
                n_fail++;
                $display("FAIL load_wr%0d: got A[%0d]=%0h @%0d want A[%0d]=%0h @%0d", i, wr_addr_q[i],
                         wr_data_q[i][31:0], wr_cyc_q[i], i + 1, op_data[i][31:0], t0 + 1 + i);
            end
        end
        if (wr_addr_q.size() >= 4) begin
            n_cmp++;
            if (wr_addr_q[3] !== '0 || wr_data_q[3] !== DW'(1) || wr_cyc_q[3] != r) begin
                n_fail++;
                $display("FAIL load_ring: got A[%0d]=%0h @%0d want A[0]=1 @%0d", wr_addr_q[3], wr_data_q[3][31:0], wr_cyc_q[3], r);
            end
        end
        n_cmp++;
        if (out_q.size() != 4) begin n_fail++; $display("FAIL load_out_count: got %0d want 4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== b_ref[i] || out_cyc_q[i] != r + 10 + 4 + i) begin
                n_fail++;
                $display("FAIL load_out%0d: got %0h @%0d want %0h @%0d", i, out_q[i][31:0], out_cyc_q[i], b_ref[i][31:0], r + 14 + i);
            end
        end
        n_cmp++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != r + 10 + 8) begin
            n_fail++; $display("FAIL load_done: got n=%0d want one pulse @%0d", done_cyc_q.size(), r + 18);
        end
    endtask

    task automatic test_backpressure();
        int t0;
        bit ok;
        clear_mon();
        fill_b(32);
        eng_en = 1'b1; eng_delay = 4; ready_mode = 1;
        start_cmd(0, 32, t0);
        wait_end(2000, ok);
        ready_mode = 0;
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: got no end, want done"); end
        n_cmp++;
        if (out_q.size() != 32) begin n_fail++; $display("FAIL bp_out_count: got %0d want 32", out_q.size()); end
        for (int i = 0; i < 32 && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== b_ref[i]) begin
                n_fail++; $display("FAIL bp_out%0d: got %0h want %0h", i, out_q[i][31:0], b_ref[i][31:0]);
            end
        end
        n_cmp++;
        if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
        n_cmp++;
        if (out_q.size() > 0 && out_cyc_q[0] < t0 + 1 + 4 + 4) begin
            n_fail++; $display("FAIL bp_first_out: got @%0d want >= @%0d", out_cyc_q[0], t0 + 9);
        end
        n_cmp++;
        if (done_cyc_q.size() != 1 || out_cyc_q.size() == 0 || done_cyc_q[0] != out_cyc_q[out_cyc_q.size() - 1] + 1) begin
            n_fail++; $display("FAIL bp_done: got n=%0d want one pulse after last word", done_cyc_q.size());
        end
    endtask

    task automatic test_timeout();
        int t0, r;
        bit ok;
        clear_mon();
        op_data[0] = rand_word();
        eng_en = 1'b0; ready_mode = 0;
        start_cmd(1, 3, t0);
        r = t0 + 2;
        feed_ops(1, 100);
        wait_end(300, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL to_end: got no end, want error"); end
        n_cmp++;
        if (err_cyc_q.size() != 1 || err_cyc_q[0] != r + TMO + 1) begin
            n_fail++; $display("FAIL to_error: got n=%0d want one pulse @%0d", err_cyc_q.size(), r + TMO + 1);
        end
        n_cmp++;
        if (wait_cnt != TMO) begin n_fail++; $display("FAIL to_wait_cycles: got %0d want %0d", wait_cnt, TMO); end
        n_cmp++;
        if (done_cyc_q.size() != 0 || wr_addr_q.size() != 2) begin
            n_fail++; $display("FAIL to_side_effects: got done=%0d writes=%0d want 0/2", done_cyc_q.size(), wr_addr_q.size());
        end
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0 || o_state !== 3'd0) begin
            n_fail++; $display("FAIL to_idle: got busy=%b state=%0d want 0/0", o_busy, o_state);
        end
        n_cmp++;
        if (mem_a[0][31:0] !== 32'h1) begin n_fail++; $display("FAIL to_flag: got %0h want 1", mem_a[0][31:0]); end
        tick();
    endtask

    task automatic test_zero_counts();
        int t0, t1, r;
        bit ok;
        clear_mon();
        eng_en = 1'b1; eng_delay = 6; ready_mode = 0;
        start_cmd(0, 0, t0);
        r = t0 + 1;
        repeat (2) tick();
        start_cmd(5, 5, t1);
        wait_end(300, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL zero_end: got no end, want done"); end
        n_cmp++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != r + 6 + 3) begin
            n_fail++; $display("FAIL zero_done: got n=%0d want one pulse @%0d", done_cyc_q.size(), r + 9);
        end
        n_cmp++;
        if (wr_addr_q.size() != 1 || beat_cyc_q.size() != 0 || (wr_cyc_q.size() > 0 && wr_cyc_q[0] != r)) begin
            n_fail++; $display("FAIL zero_writes: got writes=%0d beats=%0d want 1/0 (ring @%0d)", wr_addr_q.size(), beat_cyc_q.size(), r);
        end
        n_cmp++;
        if (out_q.size() != 0 || busy_rise_q.size() != 1) begin
            n_fail++; $display("FAIL zero_ignore_start: got outs=%0d busy_rises=%0d want 0/1", out_q.size(), busy_rise_q.size());
        end
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got busy=%b want 0", o_busy); end
        tick();
    endtask

    task automatic test_random();
        int t0, r, nl, nr, d;
        bit ok;
        for (int it = 0; it < 6; it++) begin
            clear_mon();
            nl = (it == 0) ? 31 : $urandom_range(31);
            nr = (it == 0) ? 1 : $urandom_range(32);
            d = $urandom_range(12, 1);
            for (int i = 0; i < 32; i++) op_data[i] = rand_word();
            fill_b(32);
            eng_en = 1'b1; eng_delay = d; ready_mode = 1;
            start_cmd(nl, nr, t0);
            feed_ops(nl, 60);
            wait_end(3000, ok);
            ready_mode = 0;
            n_cmp++;
            if (ok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_end: got no end, want done", it); end
            n_cmp++;
            if (beat_cyc_q.size() != nl || wr_addr_q.size() != nl + 1) begin
                n_fail++; $display("FAIL rnd%0d_counts: got beats=%0d writes=%0d want %0d/%0d", it, beat_cyc_q.size(), wr_addr_q.size(), nl, nl + 1);
                continue;
            end
            for (int i = 0; i < nl; i++) begin
                n_cmp++;
                if (wr_addr_q[i] !== AW'(i + 1) || wr_data_q[i] !== op_data[i] || wr_cyc_q[i] != beat_cyc_q[i]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_wr%0d: got A[%0d]=%0h @%0d want A[%0d]=%0h @%0d", it, i, wr_addr_q[i],
                             wr_data_q[i][31:0], wr_cyc_q[i], i + 1, op_data[i][31:0], beat_cyc_q[i]);
                end
            end
            r = (nl == 0) ? t0 + 1 : beat_cyc_q[nl - 1] + 1;
            n_cmp++;
            if (wr_addr_q[nl] !== '0 || wr_data_q[nl] !== DW'(1) || wr_cyc_q[nl] != r) begin
                n_fail++; $display("FAIL rnd%0d_ring: got A[%0d] @%0d want A[0]=1 @%0d", it, wr_addr_q[nl], wr_cyc_q[nl], r);
            end
            n_cmp++;
            if (out_q.size() != nr) begin n_fail++; $display("FAIL rnd%0d_out_count: got %0d want %0d", it, out_q.size(), nr); end
            for (int i = 0; i < nr && i < out_q.size(); i++) begin
                n_cmp++;
                if (out_q[i] !== b_ref[i]) begin
                    n_fail++; $display("FAIL rnd%0d_out%0d: got %0h want %0h", it, i, out_q[i][31:0], b_ref[i][31:0]);
                end
            end
            n_cmp++;
            if (stall_err != 0 || err_cyc_q.size() != 0) begin
                n_fail++; $display("FAIL rnd%0d_stable: got stalls=%0d errors=%0d want 0/0", it, stall_err, err_cyc_q.size());
            end
            n_cmp++;
            if (nr == 0) begin
                if (done_cyc_q.size() != 1 || done_cyc_q[0] != r + d + 3) begin
                    n_fail++; $display("FAIL rnd%0d_done: got n=%0d want one pulse @%0d", it, done_cyc_q.size(), r + d + 3);
                end
            end else if (done_cyc_q.size() != 1 || out_cyc_q.size() == 0 ||
                         done_cyc_q[0] != out_cyc_q[out_cyc_q.size() - 1] + 1 || out_cyc_q[0] < r + d + 4) begin
                n_fail++; $display("FAIL rnd%0d_done: got n=%0d want one pulse after last word, first word >= @%0d", it, done_cyc_q.size(), r + d + 4);
            end
        end
    endtask

    task automatic test_reset_mid_unload();
        int t0, guard;
        bit ok;
        clear_mon();
        fill_b(32);
        eng_en = 1'b1; eng_delay = 3; ready_mode = 1;
        start_cmd(0, 20, t0);
        guard = 0;
        while (out_q.size() < 5 && guard < 500) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (out_q.size() < 5) begin n_fail++; $display("FAIL rst_reach_unload: got %0d words want >= 5", out_q.size()); end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({o_busy, o_done, o_error, o_in_ready, o_out_valid, o_wr_en_A} !== 6'b0 || o_state !== 3'd0 || o_address_B !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got flags=%b state=%0d addrB=%0d want 0/0/0",
                     {o_busy, o_done, o_error, o_in_ready, o_out_valid, o_wr_en_A}, o_state, o_address_B);
        end
        @(posedge clk);
        #3;
        rstn = 1'b1;
        tick();
        ready_mode = 0;
        clear_mon();
        fill_b(32);
        op_data[0] = rand_word(); op_data[1] = rand_word();
        start_cmd(2, 3, t0);
        feed_ops(2, 100);
        wait_end(300, ok);
        n_cmp++;
        if (ok !== 1'b1 || done_cyc_q.size() != 1 || wr_addr_q.size() != 3) begin
            n_fail++; $display("FAIL rst_rerun: got end=%b done=%0d writes=%0d want 1/1/3", ok, done_cyc_q.size(), wr_addr_q.size());
        end
        n_cmp++;
        if (out_q.size() != 3) begin n_fail++; $display("FAIL rst_rerun_count: got %0d want 3", out_q.size()); end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== b_ref[i]) begin
                n_fail++; $display("FAIL rst_rerun_out%0d: got %0h want %0h", i, out_q[i][31:0], b_ref[i][31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_backpressure();
        test_timeout();
        test_zero_counts();
        test_random();
        test_reset_mid_unload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, want $finish before 900000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
